// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID->EX pipeline register with bubble injection, EX hold and stall watchdog.
// Optional bubble counter output o_bubble_cnt is enabled by defining IDEX_BUBBLE_CNT_EN.
module idex_stage #(
  parameter int REG_SELECT = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STALL  = 15,
  parameter int CNT_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid_0,
  input  logic                  i_is_cmp_0,
  input  logic                  i_is_write_0,
  input  logic                  i_is_load_0,
  input  logic [REG_SELECT-1:0] i_reg_a_select_0,
  input  logic [REG_SELECT-1:0] i_reg_b_select_0,
  input  logic [REG_SELECT-1:0] i_reg_c_select_0,
  input  logic [DATA_WIDTH-1:0] i_op_a_0,
  input  logic [DATA_WIDTH-1:0] i_op_b_0,
  input  logic                  i_nop,
  input  logic                  i_flush,
  input  logic                  i_ex_stall,
  output logic                  o_valid_1,
  output logic                  o_is_cmp_1,
  output logic                  o_is_write_1,
  output logic                  o_is_load_1,
  output logic [REG_SELECT-1:0] o_reg_a_select_1,
  output logic [REG_SELECT-1:0] o_reg_b_select_1,
  output logic [REG_SELECT-1:0] o_reg_c_select_1,
  output logic [DATA_WIDTH-1:0] o_op_a_1,
  output logic [DATA_WIDTH-1:0] o_op_b_1,
  output logic                  o_hold_id,
  output logic                  o_stall_err
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      o_bubble_cnt
`endif
);

  typedef enum logic {RUN, HELD} state_t;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

  state_t           state, state_next;
  logic             load_bubble, load_decode, nop_bubble;
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_flush)         state_next = RUN;
    else if (i_ex_stall) state_next = HELD;
    else                 state_next = RUN;
  end

  // EX backpressure outranks the hazard unit's nop; flush outranks both.
  always_comb begin
    load_bubble = 1'b0;
    load_decode = 1'b0;
    nop_bubble  = 1'b0;
    if (i_flush) begin
      load_bubble = 1'b1;
    end else if (!i_ex_stall) begin
      if (i_nop) begin
        load_bubble = 1'b1;
        nop_bubble  = 1'b1;
      end else begin
        load_decode = 1'b1;
      end
    end
  end

  assign o_hold_id = (i_nop | i_ex_stall) & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || load_bubble) begin
      o_valid_1        <= 1'b0;
      o_is_cmp_1       <= 1'b0;
      o_is_write_1     <= 1'b0;
      o_is_load_1      <= 1'b0;
      o_reg_a_select_1 <= '0;
      o_reg_b_select_1 <= '0;
      o_reg_c_select_1 <= '0;
      o_op_a_1         <= '0;
      o_op_b_1         <= '0;
    end else if (load_decode) begin
      o_valid_1        <= i_valid_0;
      o_is_cmp_1       <= i_is_cmp_0 & i_valid_0;
      o_is_write_1     <= i_is_write_0 & i_valid_0;
      o_is_load_1      <= i_is_load_0 & i_valid_0;
      o_reg_a_select_1 <= i_reg_a_select_0;
      o_reg_b_select_1 <= i_reg_b_select_0;
      o_reg_c_select_1 <= i_reg_c_select_0;
      o_op_a_1         <= i_op_a_0;
      o_op_b_1         <= i_op_b_0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt      <= '0;
      o_stall_err <= 1'b0;
    end else begin
      if (!o_hold_id)            wd_cnt <= '0;
      else if (wd_cnt != CNT_SAT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == STALL_LIM)   o_stall_err <= 1'b1;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)           o_bubble_cnt <= '0;
    else if (nop_bubble) o_bubble_cnt <= o_bubble_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - Table-driven and sequence checks for idex_stage.
// Define IDEX_BUBBLE_CNT_EN to also exercise the bubble counter.
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        rst, valid0, cmp0, write0, load0, nop, flush, ex_stall;
  logic [4:0]  a0, b0, c0;
  logic [31:0] opa0, opb0;
  logic        valid1, cmp1, write1, load1, hold_id, stall_err;
  logic [4:0]  a1, b1, c1;
  logic [31:0] opa1, opb1;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [3:0]  bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid_0(valid0), .i_is_cmp_0(cmp0),
    .i_is_write_0(write0), .i_is_load_0(load0),
    .i_reg_a_select_0(a0), .i_reg_b_select_0(b0), .i_reg_c_select_0(c0),
    .i_op_a_0(opa0), .i_op_b_0(opb0), .i_nop(nop), .i_flush(flush),
    .i_ex_stall(ex_stall), .o_valid_1(valid1), .o_is_cmp_1(cmp1),
    .o_is_write_1(write1), .o_is_load_1(load1),
    .o_reg_a_select_1(a1), .o_reg_b_select_1(b1), .o_reg_c_select_1(c1),
    .o_op_a_1(opa1), .o_op_b_1(opb1), .o_hold_id(hold_id),
    .o_stall_err(stall_err)
`ifdef IDEX_BUBBLE_CNT_EN
    , .o_bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    int nop, flush, stall, valid, cmp, write, load, a, b, c, opa, opb;
    int ehold, evalid, ecmp, ewrite, eload, ea, eb, ec, eopa, eopb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    {valid0, cmp0, write0, load0, nop, flush, ex_stall} = '0;
    a0 = '0; b0 = '0; c0 = '0; opa0 = '0; opb0 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_nop(input int n);
    idle();
    nop = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    vecs[0]  = '{0,0,0,1,0,1,0, 0,0,5,  'h10,0,          0, 1,0,1,0, 0,0,5,  'h10,0};
    vecs[1]  = '{1,0,0,1,0,0,1, 2,0,9,  'h30,0,          1, 0,0,0,0, 0,0,0,  0,0};
    vecs[2]  = '{0,0,0,1,0,1,1, 3,4,9,  'h30,'h20,       0, 1,0,1,1, 3,4,9,  'h30,'h20};
    vecs[3]  = '{0,0,0,0,1,1,1, 1,1,6,  'h55,1,          0, 0,0,0,0, 1,1,6,  'h55,1};
    vecs[4]  = '{0,0,0,1,1,0,0, 1,2,7,  7,8,             0, 1,1,0,0, 1,2,7,  7,8};
    vecs[5]  = '{0,0,1,1,0,1,0, 4,5,11, 'h99,'h98,       1, 1,1,0,0, 1,2,7,  7,8};
    vecs[6]  = '{1,0,1,1,0,0,0, 0,0,12, 'h12,0,          1, 1,1,0,0, 1,2,7,  7,8};
    vecs[7]  = '{0,0,1,1,0,0,1, 0,0,13, 0,0,             1, 1,1,0,0, 1,2,7,  7,8};
    vecs[8]  = '{0,0,0,1,0,1,0, 6,7,14, 'hAB,'hCD,       0, 1,0,1,0, 6,7,14, 'hAB,'hCD};
    vecs[9]  = '{1,1,1,1,0,1,0, 0,0,15, 1,0,             0, 0,0,0,0, 0,0,0,  0,0};
    vecs[10] = '{0,0,1,1,0,1,0, 0,0,16, 2,0,             1, 0,0,0,0, 0,0,0,  0,0};
    vecs[11] = '{0,1,0,1,1,0,0, 0,0,17, 0,0,             0, 0,0,0,0, 0,0,0,  0,0};
    vecs[12] = '{0,0,0,1,0,1,1, 31,31,31,'hFFFFFFFF,'h80000000, 0, 1,0,1,1, 31,31,31,'hFFFFFFFF,'h80000000};

    idle();
    rst = 1'b1;
    repeat (2) step();
    chk("reset valid", 32'(valid1), 0);
    chk("reset c_sel", 32'(c1), 0);
    chk("reset op_a", opa1, 0);
    chk("reset hold", 32'(hold_id), 0);
    chk("reset err", 32'(stall_err), 0);
`ifdef IDEX_BUBBLE_CNT_EN
    chk("reset bubble_cnt", 32'(bubble_cnt), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      nop = vecs[i].nop[0]; flush = vecs[i].flush[0]; ex_stall = vecs[i].stall[0];
      valid0 = vecs[i].valid[0]; cmp0 = vecs[i].cmp[0];
      write0 = vecs[i].write[0]; load0 = vecs[i].load[0];
      a0 = vecs[i].a[4:0]; b0 = vecs[i].b[4:0]; c0 = vecs[i].c[4:0];
      opa0 = vecs[i].opa; opb0 = vecs[i].opb;
      #1;
      chk($sformatf("v%0d hold", i), 32'(hold_id), vecs[i].ehold);
      step();
      chk($sformatf("v%0d valid", i), 32'(valid1), vecs[i].evalid);
      chk($sformatf("v%0d cmp", i), 32'(cmp1), vecs[i].ecmp);
      chk($sformatf("v%0d write", i), 32'(write1), vecs[i].ewrite);
      chk($sformatf("v%0d load", i), 32'(load1), vecs[i].eload);
      chk($sformatf("v%0d a_sel", i), 32'(a1), vecs[i].ea);
      chk($sformatf("v%0d b_sel", i), 32'(b1), vecs[i].eb);
      chk($sformatf("v%0d c_sel", i), 32'(c1), vecs[i].ec);
      chk($sformatf("v%0d op_a", i), opa1, vecs[i].eopa);
      chk($sformatf("v%0d op_b", i), opb1, vecs[i].eopb);
    end
    chk("table err", 32'(stall_err), 0);
`ifdef IDEX_BUBBLE_CNT_EN
    chk("table bubble_cnt", 32'(bubble_cnt), 1);
`endif

    // Reset while EX is held discards the held instruction.
    idle(); valid0 = 1'b1; write0 = 1'b1; c0 = 5'd7; opa0 = 32'h77;
    step();
    ex_stall = 1'b1; c0 = 5'd8;
    repeat (2) step();
    chk("held c_sel", 32'(c1), 7);
    rst = 1'b1;
    step();
    chk("rst-hold valid", 32'(valid1), 0);
    chk("rst-hold write", 32'(write1), 0);
    chk("rst-hold c_sel", 32'(c1), 0);
    chk("rst-hold op_a", opa1, 0);
    rst = 1'b0; ex_stall = 1'b0; c0 = 5'd3; opa0 = 32'h33;
    step();
    chk("post-rst valid", 32'(valid1), 1);
    chk("post-rst c_sel", 32'(c1), 3);
    chk("post-rst op_a", opa1, 32'h33);

    // Watchdog: 14 held edges stay quiet, 16 trip it, and it is sticky.
    run_nop(14);
    chk("wd 14 err", 32'(stall_err), 0);
    run_nop(2);
    chk("wd 16 err", 32'(stall_err), 1);
    idle();
    repeat (3) step();
    chk("wd sticky err", 32'(stall_err), 1);
    chk("wd sticky hold", 32'(hold_id), 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("wd rst err", 32'(stall_err), 0);

    // A flush or a released cycle clears the count.
    run_nop(14);
    idle(); flush = 1'b1; nop = 1'b1; ex_stall = 1'b1; step();
    run_nop(14);
    chk("wd flush clears", 32'(stall_err), 0);
    idle(); step();
    run_nop(14);
    chk("wd release clears", 32'(stall_err), 0);
    idle(); step();
    ex_stall = 1'b1;
    repeat (16) step();
    chk("wd ex_stall err", 32'(stall_err), 1);
    idle();
    rst = 1'b1; step(); rst = 1'b0;

`ifdef IDEX_BUBBLE_CNT_EN
    run_nop(3);
    chk("bubble_cnt 3", 32'(bubble_cnt), 3);
    idle(); flush = 1'b1; nop = 1'b1; step();
    idle(); ex_stall = 1'b1; nop = 1'b1; step();
    chk("bubble_cnt flush/stall", 32'(bubble_cnt), 3);
    idle(); rst = 1'b1; step(); rst = 1'b0;
    chk("bubble_cnt rst", 32'(bubble_cnt), 0);
    run_nop(17);
    chk("bubble_cnt wrap", 32'(bubble_cnt), 1);
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
